// File: rtl/wb_grf_if.sv
// Instruction symbols and the MEM->WB / GRF read-port bundle for wb_grf.
// The retired_cnt member exists only when WB_RETIRE_CNT_EN is defined.
package wb_grf_pkg;
  localparam int WIDTH_INSTR = 6;
  localparam logic [WIDTH_INSTR-1:0] INSTR_NOP  = 6'd0;
  localparam logic [WIDTH_INSTR-1:0] INSTR_ADDU = 6'd1;
  localparam logic [WIDTH_INSTR-1:0] INSTR_LW   = 6'd2;
  localparam logic [WIDTH_INSTR-1:0] INSTR_LH   = 6'd3;
  localparam logic [WIDTH_INSTR-1:0] INSTR_LHU  = 6'd4;
  localparam logic [WIDTH_INSTR-1:0] INSTR_LB   = 6'd5;
  localparam logic [WIDTH_INSTR-1:0] INSTR_LBU  = 6'd6;
endpackage

interface wb_grf_if;
  import wb_grf_pkg::*;

  logic [WIDTH_INSTR-1:0] instr_MEM;
  logic [31:0]            PC_MEM;
  logic [4:0]             regWriteAddr_MEM;
  logic [31:0]            regWriteData_MEM;
  logic [31:0]            memWord_MEM;
  logic [1:0]             memAddr_MEM;
  logic [4:0]             RA1;
  logic [4:0]             RA2;
  logic [31:0]            RD1;
  logic [31:0]            RD2;
  logic [WIDTH_INSTR-1:0] instr_WB;
  logic [31:0]            PC_WB;
  logic [4:0]             regaddr_WB;
  logic [31:0]            regdata_WB;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]            retired_cnt;
`endif

  modport master (
    output instr_MEM, PC_MEM, regWriteAddr_MEM, regWriteData_MEM, memWord_MEM, memAddr_MEM,
    output RA1, RA2,
    input  RD1, RD2, instr_WB, PC_WB, regaddr_WB, regdata_WB
`ifdef WB_RETIRE_CNT_EN
    , input retired_cnt
`endif
  );

  modport slave (
    input  instr_MEM, PC_MEM, regWriteAddr_MEM, regWriteData_MEM, memWord_MEM, memAddr_MEM,
    input  RA1, RA2,
    output RD1, RD2, instr_WB, PC_WB, regaddr_WB, regdata_WB
`ifdef WB_RETIRE_CNT_EN
    , output retired_cnt
`endif
  );
endinterface

// File: rtl/wb_grf.sv
// Write-back stage + 32x32 GRF: MEM result lands in WB regs on one edge, in the array on the next;
// reads forward the WB write. Optional retire counter under WB_RETIRE_CNT_EN.
module wb_grf #(
  parameter logic [31:0] SP_RESET = 32'h0000_2ffc,
  parameter logic [31:0] GP_RESET = 32'h0000_1800
) (
  input logic   clk,
  input logic   reset,
  wb_grf_if.slave bus
);
  import wb_grf_pkg::*;

  logic [31:0] data_WB;
  logic [31:0] word_WB;
  logic [1:0]  off_WB;
  logic [31:0] regs [32];
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.instr_WB   <= '0;
      bus.PC_WB      <= '0;
      bus.regaddr_WB <= '0;
      data_WB        <= '0;
      word_WB        <= '0;
      off_WB         <= '0;
    end else begin
      bus.instr_WB   <= bus.instr_MEM;
      bus.PC_WB      <= bus.PC_MEM;
      bus.regaddr_WB <= bus.regWriteAddr_MEM;
      data_WB        <= bus.regWriteData_MEM;
      word_WB        <= bus.memWord_MEM;
      off_WB         <= bus.memAddr_MEM;
    end
  end

  always_comb begin
    half_sel = off_WB[1] ? word_WB[31:16] : word_WB[15:0];
    case (off_WB)
      2'd0:    byte_sel = word_WB[7:0];
      2'd1:    byte_sel = word_WB[15:8];
      2'd2:    byte_sel = word_WB[23:16];
      default: byte_sel = word_WB[31:24];
    endcase
  end

  always_comb begin
    bus.regdata_WB = data_WB;
    case (bus.instr_WB)
      INSTR_LW:  bus.regdata_WB = word_WB;
      INSTR_LH:  bus.regdata_WB = {{16{half_sel[15]}}, half_sel};
      INSTR_LHU: bus.regdata_WB = {16'h0000, half_sel};
      INSTR_LB:  bus.regdata_WB = {{24{byte_sel[7]}}, byte_sel};
      INSTR_LBU: bus.regdata_WB = {24'h00_0000, byte_sel};
      default:   bus.regdata_WB = data_WB;
    endcase
  end

  // A write pending at a reset edge is dropped: reset reloads the whole array.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 28) ? GP_RESET : (i == 29) ? SP_RESET : 32'h0;
      end
    end else if (bus.regaddr_WB != 5'd0) begin
      regs[bus.regaddr_WB] <= bus.regdata_WB;
    end
  end

  always_comb begin
    if (bus.RA1 == 5'd0)                 bus.RD1 = 32'h0;
    else if (bus.RA1 == bus.regaddr_WB)  bus.RD1 = bus.regdata_WB;
    else                                 bus.RD1 = regs[bus.RA1];

    if (bus.RA2 == 5'd0)                 bus.RD2 = 32'h0;
    else if (bus.RA2 == bus.regaddr_WB)  bus.RD2 = bus.regdata_WB;
    else                                 bus.RD2 = regs[bus.RA2];
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset)                           retired_q <= 32'h0;
    else if (bus.instr_WB != INSTR_NOP)  retired_q <= retired_q + 32'd1;
  end

  assign bus.retired_cnt = retired_q;
`endif
endmodule

// File: tb/tb_wb_grf.sv
// Directed bench for wb_grf: architectural-state model checked every cycle plus literal pins.
module tb_wb_grf;
  import wb_grf_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errors = 0;
  logic [31:0] pc = 32'h0000_3000;

  wb_grf_if bus ();
  wb_grf dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Model: architectural register view (a result is visible as soon as it enters WB).
  logic [31:0]            m_arch [32];
  logic [WIDTH_INSTR-1:0] m_instr;
  logic [31:0]            m_pc, m_data, m_cnt;
  logic [4:0]             m_addr;
  logic                   m_ok = 1'b0;

  function automatic logic [31:0] ext(logic [WIDTH_INSTR-1:0] ins, logic [31:0] w,
                                      logic [1:0] off, logic [31:0] d);
    logic [31:0] b, h, sh;
    sh = 32'(off) * 8;
    b  = (w >> sh) & 32'hFF;
    h  = (w >> ((32'(off) / 2) * 16)) & 32'hFFFF;
    if (ins == INSTR_LW)  return w;
    if (ins == INSTR_LBU) return b;
    if (ins == INSTR_LHU) return h;
    if (ins == INSTR_LB)  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
    if (ins == INSTR_LH)  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
    return d;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_arch[i] = 32'h0;
      m_arch[28] = 32'h0000_1800;
      m_arch[29] = 32'h0000_2ffc;
      m_instr = '0; m_pc = '0; m_addr = '0; m_data = '0; m_cnt = '0;
      m_ok = 1'b1;
    end else begin
      if (m_instr != INSTR_NOP) m_cnt = m_cnt + 32'd1;
      m_instr = bus.instr_MEM;
      m_pc    = bus.PC_MEM;
      m_addr  = bus.regWriteAddr_MEM;
      m_data  = ext(bus.instr_MEM, bus.memWord_MEM, bus.memAddr_MEM, bus.regWriteData_MEM);
      if (m_addr != 5'd0) m_arch[m_addr] = m_data;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      check("instr_WB",   32'(bus.instr_WB),   32'(m_instr));
      check("PC_WB",      bus.PC_WB,           m_pc);
      check("regaddr_WB", 32'(bus.regaddr_WB), 32'(m_addr));
      check("regdata_WB", bus.regdata_WB,      m_data);
      check("RD1", bus.RD1, (bus.RA1 == 5'd0) ? 32'h0 : m_arch[bus.RA1]);
      check("RD2", bus.RD2, (bus.RA2 == 5'd0) ? 32'h0 : m_arch[bus.RA2]);
`ifdef WB_RETIRE_CNT_EN
      check("retired_cnt", bus.retired_cnt, m_cnt);
`endif
    end
  end

  task automatic drv(input logic rst, input logic [WIDTH_INSTR-1:0] ins, input logic [4:0] addr,
                     input logic [31:0] data, input logic [31:0] word, input logic [1:0] off,
                     input logic [4:0] ra1, input logic [4:0] ra2);
    @(posedge clk);
    #2;
    reset                = rst;
    pc                   = pc + 32'd4;
    bus.instr_MEM        = ins;
    bus.PC_MEM           = pc;
    bus.regWriteAddr_MEM = addr;
    bus.regWriteData_MEM = data;
    bus.memWord_MEM      = word;
    bus.memAddr_MEM      = off;
    bus.RA1              = ra1;
    bus.RA2              = ra2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  localparam logic [31:0] W = 32'h817F_FF80;
  localparam logic [31:0] J = 32'h55AA_55AA;

  initial begin
    bus.instr_MEM = INSTR_NOP; bus.PC_MEM = '0; bus.regWriteAddr_MEM = '0;
    bus.regWriteData_MEM = '0; bus.memWord_MEM = '0; bus.memAddr_MEM = '0;
    bus.RA1 = '0; bus.RA2 = '0;

    // Reset state and reset register values
    drv(1, INSTR_NOP, 0, 0, 0, 0, 0, 28);
    drv(1, INSTR_NOP, 0, 0, 0, 0, 0, 28);
    settle();
    check("rst RD1 $0", bus.RD1, 32'h0);
    check("rst RD2 $28", bus.RD2, 32'h0000_1800);
    check("rst regdata_WB", bus.regdata_WB, 32'h0);
    check("rst regaddr_WB", 32'(bus.regaddr_WB), 32'h0);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 29, 5);
    settle();
    check("rst RD1 $29", bus.RD1, 32'h0000_2ffc);
    check("rst RD2 $5", bus.RD2, 32'h0);

    // ALU result: forward in WB cycle, then from the array
    drv(0, INSTR_ADDU, 8, 32'hDEAD_BEEF, J, 1, 8, 0);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 8, 0);
    settle();
    check("addu regdata_WB", bus.regdata_WB, 32'hDEAD_BEEF);
    check("addu fwd RD1", bus.RD1, 32'hDEAD_BEEF);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 8, 8);
    settle();
    check("nop regdata_WB", bus.regdata_WB, 32'h0);
    check("array RD1 $8", bus.RD1, 32'hDEAD_BEEF);
    check("array RD2 $8", bus.RD2, 32'hDEAD_BEEF);

    // Same-cycle write and read of $8 returns the new value
    drv(0, INSTR_ADDU, 8, 32'h1111_1111, 0, 0, 8, 0);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 8, 0);
    settle();
    check("overwrite fwd RD1", bus.RD1, 32'h1111_1111);

    // Load extension
    drv(0, INSTR_LB,  3, J, W, 3, 0, 0);
    drv(0, INSTR_LBU, 4, J, W, 3, 0, 0);
    settle();
    check("LB off3", bus.regdata_WB, 32'hFFFF_FF81);
    drv(0, INSTR_LH,  5, J, W, 2, 0, 0);
    settle();
    check("LBU off3", bus.regdata_WB, 32'h0000_0081);
    drv(0, INSTR_LHU, 6, J, W, 0, 0, 0);
    settle();
    check("LH off2", bus.regdata_WB, 32'hFFFF_817F);
    drv(0, INSTR_LW,  9, J, W, 3, 0, 0);
    settle();
    check("LHU off0", bus.regdata_WB, 32'h0000_FF80);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 9, 3);
    settle();
    check("LW off3", bus.regdata_WB, 32'h817F_FF80);
    check("LW fwd RD1", bus.RD1, 32'h817F_FF80);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 3, 5);
    settle();
    check("array $3", bus.RD1, 32'hFFFF_FF81);
    check("array $5", bus.RD2, 32'hFFFF_817F);

    // Write to $0 is neither stored nor forwarded
    drv(0, INSTR_ADDU, 0, 32'h1234, 0, 0, 0, 0);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 0, 0);
    settle();
    check("$0 wr RD1", bus.RD1, 32'h0);
    check("$0 wr RD2", bus.RD2, 32'h0);
    check("$0 wr regdata_WB", bus.regdata_WB, 32'h1234);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 0, 0);
    settle();
    check("$0 after RD1", bus.RD1, 32'h0);
    check("$0 after RD2", bus.RD2, 32'h0);

    // Reset on the WB edge drops the write to $7
    drv(0, INSTR_ADDU, 7, 32'd5, 0, 0, 7, 29);
    drv(1, INSTR_NOP, 0, 0, 0, 0, 7, 29);
    settle();
    check("$7 fwd before rst", bus.RD1, 32'd5);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 7, 8);
    settle();
    check("$7 after rst", bus.RD1, 32'h0);
    check("$8 after rst", bus.RD2, 32'h0);

`ifdef WB_RETIRE_CNT_EN
    drv(1, INSTR_NOP, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) begin
      if (k == 3 || k == 7 || k == 11) drv(0, INSTR_NOP, 0, 0, 0, 0, 1, 2);
      else drv(0, INSTR_ADDU, 5'(k + 1), 32'(k * 3), 0, 0, 1, 2);
    end
    drv(0, INSTR_NOP, 0, 0, 0, 0, 0, 0);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 0, 0);
    settle();
    check("retired 10", bus.retired_cnt, 32'd10);
    dut.retired_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    drv(0, INSTR_ADDU, 1, 32'd1, 0, 0, 0, 0);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 0, 0);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 0, 0);
    settle();
    check("retired wrap", bus.retired_cnt, 32'h0);
`endif

    drv(0, INSTR_NOP, 0, 0, 0, 0, 0, 0);
    drv(0, INSTR_NOP, 0, 0, 0, 0, 0, 0);
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, limit 200000 reached");
    $fatal(1, "timeout");
  end
endmodule
